// File: rtl/alu_exec_ctrl_pkg.sv
// rtl/alu_exec_ctrl_pkg.sv - op-codes, PSR bit indices, FSM states and op classification
package alu_exec_ctrl_pkg;

  localparam logic [7:0] OP_AND  = 8'h01;
  localparam logic [7:0] OP_OR   = 8'h02;
  localparam logic [7:0] OP_XOR  = 8'h03;
  localparam logic [7:0] OP_ADD  = 8'h05;
  localparam logic [7:0] OP_NOT  = 8'h07;
  localparam logic [7:0] OP_SUB  = 8'h09;
  localparam logic [7:0] OP_CMP  = 8'h0B;
  localparam logic [7:0] OP_MOV  = 8'h0D;
  localparam logic [7:0] OP_LSH  = 8'h84;
  localparam logic [7:0] OP_ASHU = 8'h86;

  localparam int PSR_C = 0;
  localparam int PSR_L = 1;
  localparam int PSR_F = 2;
  localparam int PSR_Z = 3;
  localparam int PSR_N = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  // Bitwise ops take a zero-extended immediate; everything else sign-extends.
  function automatic logic op_is_logic(input logic [7:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_XOR);
  endfunction

  // These ops present the source operand on ALU A and the destination on ALU B.
  function automatic logic op_swaps(input logic [7:0] op);
    return (op == OP_CMP) || (op == OP_MOV) || (op == OP_NOT);
  endfunction

  function automatic logic op_writes_reg(input logic [7:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR) ||
           (op == OP_XOR) || (op == OP_LSH) || (op == OP_ASHU) ||
           (op == OP_MOV) || (op == OP_NOT);
  endfunction

  function automatic logic op_writes_psr(input logic [7:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR) ||
           (op == OP_XOR) || (op == OP_CMP) || (op == OP_LSH) || (op == OP_ASHU);
  endfunction

  function automatic logic op_known(input logic [7:0] op);
    return op_writes_reg(op) || (op == OP_CMP);
  endfunction

endpackage

// File: rtl/alu_exec_ctrl_regfile_16x16.sv
// rtl/alu_exec_ctrl_regfile_16x16.sv - general register file, one write port, two read ports, debug read
module regfile_16x16 #(
  parameter int NREGS = 16,
  parameter int DW    = 16,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] ra_addr,
  output logic [DW-1:0] ra_data,
  input  logic [AW-1:0] rb_addr,
  output logic [DW-1:0] rb_data,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  logic [DW-1:0] mem_q [NREGS];

  // Synchronous clear on reset, otherwise a single write per cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign ra_data  = mem_q[ra_addr];
  assign rb_data  = mem_q[rb_addr];
  assign dbg_data = mem_q[dbg_addr];

endmodule

// File: rtl/alu_exec_ctrl.sv
// rtl/alu_exec_ctrl.sv - four-state execution controller around an external 16-bit ALU
module alu_exec_ctrl
  import alu_exec_ctrl_pkg::*;
#(
  parameter int NREGS = 16,
  parameter int DW    = 16,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inst_valid,
  output logic          inst_ready,
  input  logic [7:0]    inst_op,
  input  logic [AW-1:0] inst_rdest,
  input  logic [AW-1:0] inst_rsrc,
  input  logic [7:0]    inst_imm,
  input  logic          inst_use_imm,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [7:0]    alu_op,
  input  logic [DW-1:0] alu_result,
  input  logic [4:0]    alu_flags,
  output logic [4:0]    psr,
  output logic          done,
  output logic          illegal_op,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  state_t        state_q;
  logic [7:0]    op_q;
  logic [AW-1:0] rdest_q;
  logic [AW-1:0] rsrc_q;
  logic [7:0]    imm_q;
  logic          use_imm_q;
  logic [DW-1:0] opd_dst_q;
  logic [DW-1:0] opd_src_q;
  logic [DW-1:0] res_q;
  logic [4:0]    flags_q;
  logic [4:0]    psr_q;
  logic          done_q;
  logic          ill_q;
  logic          ready_q;

  logic [DW-1:0] rd_data;
  logic [DW-1:0] rs_data;
  logic [DW-1:0] imm_ext;
  logic [DW-1:0] opd_src_d;
  logic          rf_we;

  regfile_16x16 #(.NREGS(NREGS), .DW(DW)) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .we       (rf_we),
    .waddr    (rdest_q),
    .wdata    (res_q),
    .ra_addr  (rdest_q),
    .ra_data  (rd_data),
    .rb_addr  (rsrc_q),
    .rb_data  (rs_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // The write lands at the end of WB, so the next READ already sees it.
  assign rf_we = (state_q == ST_WB) && op_writes_reg(op_q);

  // Immediate extension depends on the op class; the source operand picks reg or immediate.
  always_comb begin
    imm_ext = op_is_logic(op_q) ? {{(DW-8){1'b0}}, imm_q} : {{(DW-8){imm_q[7]}}, imm_q};
    opd_src_d = use_imm_q ? imm_ext : rs_data;
  end

  // ALU inputs are only driven during EXEC; some ops present the operands swapped.
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = '0;
    if (state_q == ST_EXEC) begin
      alu_op = op_q;
      if (op_swaps(op_q)) begin
        alu_a = opd_src_q;
        alu_b = opd_dst_q;
      end else begin
        alu_a = opd_dst_q;
        alu_b = opd_src_q;
      end
    end
  end

  // Main FSM: IDLE -> READ -> EXEC -> WB, with registered handshake and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      rdest_q   <= '0;
      rsrc_q    <= '0;
      imm_q     <= '0;
      use_imm_q <= 1'b0;
      opd_dst_q <= '0;
      opd_src_q <= '0;
      res_q     <= '0;
      flags_q   <= '0;
      psr_q     <= '0;
      done_q    <= 1'b0;
      ill_q     <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      done_q <= 1'b0;
      ill_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (inst_valid) begin
            op_q      <= inst_op;
            rdest_q   <= inst_rdest;
            rsrc_q    <= inst_rsrc;
            imm_q     <= inst_imm;
            use_imm_q <= inst_use_imm;
            ready_q   <= 1'b0;
            state_q   <= ST_READ;
          end
        end
        ST_READ: begin
          opd_dst_q <= rd_data;
          opd_src_q <= opd_src_d;
          state_q   <= ST_EXEC;
        end
        ST_EXEC: begin
          res_q   <= alu_result;
          flags_q <= alu_flags;
          done_q  <= 1'b1;
          ill_q   <= !op_known(op_q);
          state_q <= ST_WB;
        end
        ST_WB: begin
          if (op_writes_psr(op_q)) begin
            psr_q <= flags_q;
          end
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign inst_ready = ready_q;
  assign psr        = psr_q;
  assign done       = done_q;
  assign illegal_op = ill_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// tb/tb_alu_exec_ctrl.sv - scoreboard bench for alu_exec_ctrl with a behavioural ALU
module tb_alu_exec_ctrl;
  import alu_exec_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inst_valid = 1'b0;
  logic        inst_ready;
  logic [7:0]  inst_op = '0;
  logic [3:0]  inst_rdest = '0;
  logic [3:0]  inst_rsrc = '0;
  logic [7:0]  inst_imm = '0;
  logic        inst_use_imm = 1'b0;
  logic [15:0] alu_a, alu_b;
  logic [7:0]  alu_op;
  logic [15:0] alu_result;
  logic [4:0]  alu_flags;
  logic [4:0]  psr;
  logic        done, illegal_op;
  logic [3:0]  dbg_addr = '0;
  logic [15:0] dbg_data;

  int n_vec = 0;
  int n_err = 0;
  logic init_done = 1'b0;

  typedef struct {
    logic [3:0]  rd;
    logic [15:0] val;
    logic [4:0]  psr;
    logic        ill;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  alu_exec_ctrl dut (
    .clk(clk), .reset(reset),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_op(inst_op), .inst_rdest(inst_rdest), .inst_rsrc(inst_rsrc),
    .inst_imm(inst_imm), .inst_use_imm(inst_use_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .psr(psr), .done(done), .illegal_op(illegal_op),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Behavioural ALU: flags {N,Z,F,L,C}
  logic [15:0] m_res;
  logic        m_c, m_f;
  always_comb begin
    m_res = '0;
    m_c = 1'b0;
    m_f = 1'b0;
    alu_flags = '0;
    case (alu_op)
      OP_ADD: begin
        {m_c, m_res} = {1'b0, alu_a} + {1'b0, alu_b};
        m_f = (alu_a[15] == alu_b[15]) && (m_res[15] != alu_a[15]);
      end
      OP_SUB: begin
        m_res = alu_a - alu_b;
        m_c = alu_a < alu_b;
        m_f = (alu_a[15] != alu_b[15]) && (m_res[15] != alu_a[15]);
      end
      OP_AND:  m_res = alu_a & alu_b;
      OP_OR:   m_res = alu_a | alu_b;
      OP_XOR:  m_res = alu_a ^ alu_b;
      OP_MOV:  m_res = alu_a;
      OP_NOT:  m_res = ~alu_a;
      OP_LSH:  m_res = alu_b[15] ? (alu_a >> (16'd0 - alu_b)) : (alu_a << alu_b);
      OP_ASHU: m_res = alu_b[15] ? 16'($signed(alu_a) >>> (16'd0 - alu_b)) : (alu_a << alu_b);
      default: m_res = '0;
    endcase
    alu_result = m_res;
    if (alu_op == OP_CMP) begin
      alu_flags[PSR_N] = $signed(alu_a) > $signed(alu_b);
      alu_flags[PSR_Z] = alu_a == alu_b;
      alu_flags[PSR_L] = alu_a > alu_b;
    end else begin
      alu_flags[PSR_N] = m_res[15];
      alu_flags[PSR_Z] = m_res == 16'h0000;
      alu_flags[PSR_F] = m_f;
      alu_flags[PSR_C] = m_c;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: initial register sweep, then pop one expectation per done pulse
  initial begin
    for (int n = 0; n < 50 && reset; n++) @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      dbg_addr = 4'(i);
      #1;
      chk($sformatf("reset_r%0d", i), 32'(dbg_data), 32'h0);
      @(negedge clk);
    end
    init_done = 1'b1;
    forever begin
      @(negedge clk);
      if (done) begin
        if (sb.size() == 0) begin
          chk("spurious_done", 32'(done), 32'h0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("illegal_op", 32'(illegal_op), 32'(e.ill));
          chk("alu_idle_in_wb", {alu_op, alu_a | alu_b}, 32'h0);
          dbg_addr = e.rd;
          @(negedge clk);
          chk($sformatf("reg_r%0d", e.rd), 32'(dbg_data), 32'(e.val));
          chk("psr", 32'(psr), 32'(e.psr));
        end
      end
    end
  end

  task automatic issue(input logic [7:0] op, input logic [3:0] rd, input logic [3:0] rs,
                       input logic [7:0] imm, input logic ui, input logic [15:0] ev,
                       input logic [4:0] ep, input logic ill, input logic chk_lat);
    int n;
    int lat;
    logic rdy_bad;
    @(negedge clk);
    inst_op = op; inst_rdest = rd; inst_rsrc = rs; inst_imm = imm; inst_use_imm = ui;
    inst_valid = 1'b1;
    n = 0;
    while (!inst_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!inst_ready) begin
      chk("accept_timeout", 32'(inst_ready), 32'h1);
      inst_valid = 1'b0;
      return;
    end
    sb.push_back('{rd, ev, ep, ill});
    lat = 1;
    rdy_bad = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      rdy_bad |= inst_ready;
    end while (!done && lat < 12);
    if (chk_lat) chk("latency", 32'(lat), 32'd4);
    chk("ready_low_busy", 32'(rdy_bad), 32'h0);
    inst_valid = 1'b0;
  endtask

  // Stimulus
  initial begin
    int n;
    int lat;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_psr", 32'(psr), 32'h0);
    chk("reset_ready", 32'(inst_ready), 32'h1);
    chk("reset_done", {done, illegal_op}, 32'h0);
    n = 0;
    while (!init_done && n < 100) begin
      @(negedge clk);
      n++;
    end

    //     op       rd rs imm    ui expected   psr       ill lat
    issue(OP_MOV,  1, 0, 8'h0A, 1, 16'h000A, 5'b00000, 0, 0);
    issue(OP_MOV,  2, 0, 8'h03, 1, 16'h0003, 5'b00000, 0, 0);
    issue(OP_SUB,  1, 2, 8'h00, 0, 16'h0007, 5'b00000, 0, 1);
    issue(OP_CMP,  2, 1, 8'h00, 0, 16'h0003, 5'b10010, 0, 1);
    issue(OP_MOV,  3, 0, 8'h01, 1, 16'h0001, 5'b10010, 0, 0);
    issue(OP_LSH,  3, 0, 8'hFF, 1, 16'h0000, 5'b01000, 0, 1);
    issue(OP_MOV,  4, 0, 8'h80, 1, 16'hFF80, 5'b01000, 0, 0);
    issue(OP_LSH,  4, 0, 8'h08, 1, 16'h8000, 5'b10000, 0, 0);
    issue(OP_ASHU, 4, 0, 8'hFF, 1, 16'hC000, 5'b10000, 0, 0);
    issue(OP_MOV,  5, 0, 8'h00, 1, 16'h0000, 5'b10000, 0, 0);
    issue(OP_OR,   5, 0, 8'hFF, 1, 16'h00FF, 5'b00000, 0, 0);
    issue(8'hEE,   5, 1, 8'h12, 1, 16'h00FF, 5'b00000, 1, 1);
    issue(OP_NOT,  5, 5, 8'h00, 0, 16'hFF00, 5'b00000, 0, 0);
    issue(OP_ADD,  1, 0, 8'hFE, 1, 16'h0005, 5'b00001, 0, 0);
    issue(OP_XOR,  1, 1, 8'h00, 0, 16'h0000, 5'b01000, 0, 0);
    issue(OP_MOV,  6, 0, 8'h05, 1, 16'h0005, 5'b01000, 0, 0);
    issue(OP_MOV,  7, 0, 8'h02, 1, 16'h0002, 5'b01000, 0, 0);

    // ADD r6 = r6 + r7 aborted by reset in EXEC; valid stays high and is re-accepted
    @(negedge clk);
    inst_op = OP_ADD; inst_rdest = 4'd6; inst_rsrc = 4'd7; inst_imm = 8'h00; inst_use_imm = 1'b0;
    inst_valid = 1'b1;
    n = 0;
    while (!inst_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("ready_after_abort", 32'(inst_ready), 32'h1);
    chk("no_done_on_abort", {done, illegal_op}, 32'h0);
    chk("psr_after_abort", 32'(psr), 32'h0);
    reset = 1'b0;
    sb.push_back('{4'd6, 16'h0000, 5'b01000, 1'b0});
    lat = 1;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < 12);
    chk("latency_after_reset", 32'(lat), 32'd4);
    inst_valid = 1'b0;

    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1);
  end

endmodule

// File: doc/alu_exec_ctrl.md
Name: alu_exec_ctrl

Overview:
- Execution controller wrapped around the existing 16-bit ALU, which stays a separate instance.
- Holds the 16 x 16-bit general register file and the 5-bit processor status register (PSR).
- Accepts one decoded instruction per valid/ready handshake, reads operands, drives the ALU, and writes back the result and flags.
- Sits between the decoder and the ALU: upstream operand source and downstream result/flag sink.

Parameters:
- NREGS, 16, number of general registers; address width is log2(NREGS) = 4.
- DW, 16, data width; must match the ALU width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- inst_valid  in  1  decoder presents an instruction.
- inst_ready  out  1  controller can accept; high only in IDLE.
- inst_op  in  8  ALU op-code, same encoding as the ALU Op input.
- inst_rdest  in  4  destination / first operand register.
- inst_rsrc  in  4  source register.
- inst_imm  in  8  immediate.
- inst_use_imm  in  1  1 = use the immediate instead of Rsrc.
- alu_a  out  16  to ALU A.
- alu_b  out  16  to ALU B.
- alu_op  out  8  to ALU Op.
- alu_result  in  16  from ALU Output.
- alu_flags  in  5  from ALU Flags; bits are {N, Z, F, L, C}, bit 0 = C.
- psr  out  5  current PSR.
- done  out  1  one-cycle pulse when an instruction retires.
- illegal_op  out  1  pulses together with done for an unrecognised op.
- dbg_addr  in  4  debug read address.
- dbg_data  out  16  combinational read of reg[dbg_addr].

Behaviour:
- States: IDLE -> READ -> EXEC -> WB -> IDLE. No other transitions except reset.
- IDLE:
  - inst_ready = 1.
  - On inst_valid, latch op/rdest/rsrc/imm/use_imm and go to READ.
- READ:
  - Latch opd_d = reg[rdest].
  - Latch opd_s = reg[rsrc], or the extended immediate when use_imm = 1.
  - Immediate extension: zero-extend for AND/OR/XOR; sign-extend for all other ops.
- EXEC:
  - Drive alu_op = latched op.
  - ADD, SUB, AND, OR, XOR, LSH, ASHU: alu_a = opd_d, alu_b = opd_s.
  - CMP, MOV, NOT: alu_a = opd_s, alu_b = opd_d.
  - Capture alu_result and alu_flags into internal registers at the end of the cycle.
- WB:
  - Write the captured result to reg[rdest] for ADD, SUB, AND, OR, XOR, LSH, ASHU, MOV, NOT.
  - CMP: no register write.
  - PSR <= captured flags for ADD, SUB, AND, OR, XOR, CMP, LSH, ASHU.
  - MOV, NOT: PSR unchanged.
  - Unrecognised op: no register write, PSR unchanged, illegal_op = 1.
  - done = 1 for every op.
- Outside EXEC: alu_a = 0, alu_b = 0, alu_op = 0.
- Latency: 4 cycles from handshake to done. Peak throughput is 1 instruction per 4 cycles.
- The register write is visible on dbg_data the cycle after WB. The next instruction's READ therefore sees the previous result, so there is no hazard.
- rdest == rsrc is legal; both operands read the same value.
- inst_valid outside IDLE is ignored (inst_ready = 0); the decoder must hold the instruction until accepted.
- Reset:
  - All registers and PSR = 0; state = IDLE.
  - done = 0, illegal_op = 0, inst_ready = 1 on the cycle after reset deasserts.
  - Reset in any state aborts the instruction with no register or PSR write.

Decomposition:
- Shared package holds:
  - op-code constants: ADD 0x05, SUB 0x09, OR 0x02, AND 0x01, XOR 0x03, CMP 0x0B, MOV 0x0D, LSH 0x84, ASHU 0x86, NOT 0x07;
  - PSR bit indices: C = 0, L = 1, F = 2, Z = 3, N = 4;
  - the state encoding.
- One natural sub-module: regfile_16x16, with two synchronous-write/asynchronous-read ports plus the debug read port.

Test Plan:
- Reset, then dbg read of r0..r15 -> all 0; psr = 0; inst_ready = 1.
- r1 = 10, r2 = 3 (loaded via MOV imm); SUB rdest = 1, rsrc = 2 -> done 4 cycles after handshake; r1 = 7; psr = 0.
- r1 = 7, r2 = 3; CMP rdest = 2, rsrc = 1 -> r2 stays 3; psr L = 1, N = 1, Z = 0 (psr = 5'b10010).
- r3 = 0x0001; LSH rdest = 3, imm = 0xFF (-1) -> r3 = 0x0000, psr Z = 1. r4 = 0x8000; ASHU imm 0xFF -> r4 = 0xC000.
- Op 0xEE -> illegal_op and done pulse together; registers and psr unchanged. Then NOT r5 (was 0x00FF) -> r5 = 0xFF00, psr unchanged.
- Reset asserted during EXEC of ADD r6 = r6 + r7 -> r6 = 0 and state IDLE next cycle, no done pulse; inst_valid held high through WB -> accepted only after IDLE returns.
